// File: rtl/shift_mul_ctrl.sv
// Sequential shift-and-add multiplier controller: one multiplier bit per cycle,
// returns the product modulo 2^size and an exact overflow flag.
module shift_mul_ctrl #(
  parameter int size       = 32,
  parameter int cnt_bits   = 6,
  parameter bit early_exit = 1'b0
) (
  input  logic            clk,
  input  logic            r,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] p,
  output logic            ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [cnt_bits-1:0] LAST_CNT = cnt_bits'(size - 1);

  state_t              state_reg;
  logic [size-1:0]     mcand_reg;
  logic [size-1:0]     mplier_reg;
  logic [size-1:0]     acc_reg;
  logic [cnt_bits-1:0] cnt_reg;
  logic                lost_reg;
  logic                carry_seen_reg;

  logic [size:0]       sum;
  logic [size-1:0]     acc_next;
  logic                carry_seen_next;
  logic                last_step;

  // A partial product overflows either through a carry out of the adder or
  // because its multiplicand already had a set bit shifted off the top.
  always_comb begin
    sum             = {1'b0, acc_reg} + {1'b0, mcand_reg};
    acc_next        = acc_reg;
    carry_seen_next = carry_seen_reg;
    if (mplier_reg[0]) begin
      acc_next        = sum[size-1:0];
      carry_seen_next = carry_seen_reg | sum[size] | lost_reg;
    end
    last_step = (cnt_reg == LAST_CNT) || (early_exit && ((mplier_reg >> 1) == '0));
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_reg      <= IDLE;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      lost_reg       <= 1'b0;
      carry_seen_reg <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      p              <= '0;
      ovf            <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= RUN;
            mcand_reg      <= a;
            mplier_reg     <= b;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            lost_reg       <= 1'b0;
            carry_seen_reg <= 1'b0;
            busy           <= 1'b1;
          end
        end
        RUN: begin
          acc_reg        <= acc_next;
          carry_seen_reg <= carry_seen_next;
          lost_reg       <= lost_reg | mcand_reg[size-1];
          mcand_reg      <= mcand_reg << 1;
          mplier_reg     <= mplier_reg >> 1;
          cnt_reg        <= cnt_reg + 1'b1;
          if (last_step) begin
            state_reg <= DONE;
            done      <= 1'b1;
            p         <= acc_next;
            ovf       <= carry_seen_next;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_mul_ctrl.sv
// Directed bench for shift_mul_ctrl: a fixed-latency instance and an early-exit
// instance, with expected results queued at start and compared at done.
module tb_shift_mul_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r0, start0, busy0, done0, ovf0;
  logic [31:0] a0, b0, p0;
  logic        r1, start1, busy1, done1, ovf1;
  logic [31:0] a1, b1, p1;

  shift_mul_ctrl #(.size(32), .cnt_bits(6), .early_exit(1'b0)) u_dut0 (
    .clk(clk), .r(r0), .start(start0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .p(p0), .ovf(ovf0)
  );

  shift_mul_ctrl #(.size(32), .cnt_bits(6), .early_exit(1'b1)) u_dut1 (
    .clk(clk), .r(r1), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .p(p1), .ovf(ovf1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic get_busy(input bit ee);
    return ee ? busy1 : busy0;
  endfunction
  function automatic logic get_done(input bit ee);
    return ee ? done1 : done0;
  endfunction
  function automatic logic get_ovf(input bit ee);
    return ee ? ovf1 : ovf0;
  endfunction
  function automatic logic [31:0] get_p(input bit ee);
    return ee ? p1 : p0;
  endfunction

  // Latency model: fixed width, or position of the highest set multiplier bit.
  function automatic int calc_lat(input bit ee, input logic [31:0] bb);
    int k;
    if (!ee) return 32;
    k = 1;
    for (int i = 0; i < 32; i++)
      if (bb[i]) k = i + 1;
    return k;
  endfunction

  task automatic drive(input bit ee, input logic s, input logic [31:0] aa, input logic [31:0] bb);
    if (ee) begin
      start1 = s; a1 = aa; b1 = bb;
    end else begin
      start0 = s; a0 = aa; b0 = bb;
    end
  endtask

  task automatic run_op(input bit ee, input logic [31:0] aa, input logic [31:0] bb, input bit poke);
    exp_t        e;
    logic [63:0] full;
    int          cyc;
    int          busy_n;
    int          extra_done;
    full  = {32'b0, aa} * {32'b0, bb};
    e.p   = full[31:0];
    e.ovf = (full[63:32] != 32'b0);
    e.lat = calc_lat(ee, bb);
    @(negedge clk);
    drive(ee, 1'b1, aa, bb);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    drive(ee, 1'b0, $urandom, $urandom);
    cyc    = 0;
    busy_n = 0;
    while (cyc < 200) begin
      if (get_busy(ee)) busy_n++;
      if (get_done(ee)) break;
      drive(ee, poke && (cyc == 5), 32'd7, 32'd7);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (!get_done(ee)) chk("done_timeout", 64'(get_done(ee)), 64'd1);
    e = sb.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("product", 64'(get_p(ee)), 64'(e.p));
    chk("ovf", 64'(get_ovf(ee)), 64'(e.ovf));
    chk("busy_cycles", 64'(busy_n), 64'(e.lat + 1));
    $display("[TB] op ee=%0d a=%h b=%h p=%h ovf=%0d lat=%0d", ee, aa, bb, get_p(ee), get_ovf(ee), cyc);
    if (poke) drive(ee, 1'b1, 32'd7, 32'd7);
    @(posedge clk);
    @(negedge clk);
    drive(ee, 1'b0, 32'd7, 32'd7);
    chk("done_one_pulse", 64'(get_done(ee)), 64'd0);
    chk("busy_idle", 64'(get_busy(ee)), 64'd0);
    chk("p_held", 64'(get_p(ee)), 64'(e.p));
    if (poke) begin
      extra_done = 0;
      repeat (40) begin
        @(posedge clk);
        @(negedge clk);
        if (get_done(ee)) extra_done++;
      end
      chk("ignored_start_no_done", 64'(extra_done), 64'd0);
      chk("ignored_start_p", 64'(get_p(ee)), 64'(e.p));
    end
  endtask

  initial begin
    int done_hits;
    r0 = 1'b1; start0 = 1'b0; a0 = '0; b0 = '0;
    r1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    r0 = 1'b0;
    r1 = 1'b0;
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_p0", 64'(p0), 64'd0);
    chk("rst_ovf0", 64'(ovf0), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_p1", 64'(p1), 64'd0);
    chk("rst_ovf1", 64'(ovf1), 64'd0);

    run_op(1'b0, 32'd3, 32'd5, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'd1, 1'b0);
    run_op(1'b0, 32'd3, 32'd5, 1'b1);
    run_op(1'b0, 32'h0000_1234, 32'h0000_00FF, 1'b0);

    // Reset at E0+10 discards the operation in flight.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0001_2345, 32'h0000_FFFF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, $urandom, $urandom);
    repeat (9) @(posedge clk);
    @(negedge clk);
    r0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r0 = 1'b0;
    chk("midrst_busy", 64'(busy0), 64'd0);
    chk("midrst_done", 64'(done0), 64'd0);
    chk("midrst_p", 64'(p0), 64'd0);
    chk("midrst_ovf", 64'(ovf0), 64'd0);
    done_hits = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) done_hits++;
    end
    chk("midrst_no_done", 64'(done_hits), 64'd0);
    $display("[TB] mid-operation reset: busy=%0d p=%h done_after=%0d", busy0, p0, done_hits);
    run_op(1'b0, 32'd6, 32'd7, 1'b0);

    run_op(1'b1, 32'd9, 32'd1, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, 32'd2, 32'h0000_0100, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'h4000_0000, 32'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_mul_ctrl.md
Name: shift_mul_ctrl

Overview:
- Sequential shift-and-add multiplier controller for the ALU's multiply path.
- Loads two operands on a start handshake, then sequences an internal left-shifting multiplicand register, a right-shifting multiplier register and an accumulator, one multiplier bit per cycle.
- Returns the product modulo 2^size plus an overflow flag.
- Used by the instruction sequencer for the multiply opcode; one operation in flight at a time.

Parameters:
- size, 32, operand and product width in bits.
- cnt_bits, 6, bit-counter width; must satisfy 2^cnt_bits > size.
- early_exit, 0, when 1 the operation ends as soon as the remaining multiplier bits are all zero.

Ports:
- clk  input  1  clock, all state updates on posedge.
- r  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  size  multiplicand; sampled with start.
- b  input  size  multiplier; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, high in DONE.
- p  output  size  product mod 2^size; holds its value until the next completion.
- ovf  output  1  true product >= 2^size; valid with done, held alongside p.

Behaviour:
- Clock and reset: one clock, clk. Reset r is synchronous and active-high.
- Reset values: state=IDLE; busy=0; done=0; p=0; ovf=0; internal registers and counter=0.
- Reset has priority over every other input, including mid-operation. An in-flight operation is discarded and produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → RUN.
  - At the same edge: mcand<=a, mplier<=b, acc<=0, cnt<=0, lost<=0, carry_seen<=0.
  - start=0: remain in IDLE, no register change.
- RUN, each edge:
  - If mplier[0]=1: acc<=acc+mcand, truncated to size bits. A carry out of bit size-1 sets carry_seen.
  - If mplier[0]=1 and lost=1: set carry_seen (a partial product exceeded size bits).
  - lost<=lost | mcand[size-1]. This is evaluated after the partial-product check, so the bit shifted out on this edge affects only later bits.
  - mcand<=mcand<<1, zero fill. mplier<=mplier>>1, zero fill. cnt<=cnt+1.
  - Transition to DONE when cnt==size-1.
  - When early_exit=1, also transition to DONE when (mplier>>1)==0.
  - RUN always lasts at least one edge, including for b=0.
- DONE, one cycle:
  - done=1, busy=1.
  - p and ovf are registered on the edge entering DONE. p=final acc; ovf=final carry_seen.
  - Next edge → IDLE unconditionally.
- start is ignored outside IDLE, including during DONE. Back-to-back operations therefore need at least one IDLE cycle between done and the next start.
- Latency with early_exit=0: done is visible after edge E0+size, independent of the operands. For size=32, RUN lasts 32 edges.
- Latency with early_exit=1: done is visible after edge E0+k, where k=max(1, index of the highest set bit of b + 1).
- Inputs a and b may change freely after E0; they are not re-sampled.
- ovf is exact: it is set iff the infinite-precision a*b >= 2^size.
- The counter never wraps because 2^cnt_bits > size. cnt is not observable at the ports.

Test Plan:
- Basic product: reset, then start with a=3, b=5 (early_exit=0) → done pulses exactly once after E0+32; p=15, ovf=0; busy high for 33 cycles; p remains 15 after returning to IDLE.
- All-ones operands: a=b=0xFFFFFFFF → p=0x00000001, ovf=1.
- Lost-bit overflow: a=0x00010000, b=0x00010000 → p=0, ovf=1. Separately, a=0x80000000, b=1 → p=0x80000000, ovf=0.
- Start while busy: start pulses during RUN and during the DONE cycle with a=7, b=7 → ignored; first result unchanged; no second done until a new start is issued in IDLE.
- Reset mid-operation: r=1 for one cycle at E0+10 → after that edge busy=0, done=0, p=0, ovf=0; no done follows; a subsequent start with a=6, b=7 → p=42.
- early_exit=1 instance:
  - b=1, a=9 → done visible after E0+1, p=9.
  - b=0 → done after E0+1, p=0, ovf=0.
  - b=0x00000100, a=2 → done after E0+9, p=0x200.
